flash_byte_reader: RTL

- Upstream stage of the ROM loader.
- Serves 16-bit word reads from the DE2-115 8 MB parallel flash, which has an 8-bit data bus.
- Each requested word takes two timed byte reads; the bytes are assembled into one word.
- The word goes back to the requester over the toggle req/ack handshake the loader already uses.
- The block also sequences the flash reset pin after board reset.

---
 rtl/flash_byte_reader_if.sv | 18 +
 rtl/flash_byte_reader.sv | 136 +++++++++++++
 2 files changed

// File: rtl/flash_byte_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : flash_byte_reader_if
//  Description : Toggle req/ack word-read handshake between the ROM loader
//                (master) and flash_byte_reader (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface flash_byte_reader_if;
   logic [22:0] iaddr;   // word-aligned byte address, bit 0 ignored
   logic        ireq;    // toggle request
   logic        oack;    // toggle acknowledge
   logic [15:0] odata;   // assembled word
   logic        oready;  // flash reset sequence complete

   modport master (output iaddr, output ireq, input oack, input odata, input oready);
   modport slave  (input iaddr, input ireq, output oack, output odata, output oready);
endinterface
`default_nettype wire

// File: rtl/flash_byte_reader.sv
`default_nettype none
// ============================================================================
//  Module      : flash_byte_reader
//  Description : Serves 16-bit word reads from an 8-bit parallel flash using
//                two timed byte reads, returned over a toggle req/ack
//                handshake. Also sequences the flash reset pin after board
//                reset.
//  Options     : FLASH_BYTESWAP_EN - when defined, odata = {odd, even};
//                otherwise odata = {even, odd}. Read order and timing are
//                identical in both builds.
//  Revision    : 1.0  initial release
// ============================================================================
module flash_byte_reader #(
   parameter int ACCESS_CYCLES   = 6,   // cycles each byte read is held (>= 2)
   parameter int RST_LOW_CYCLES  = 32,  // cycles ofl_rst_n held low
   parameter int RST_WAIT_CYCLES = 64   // cycles after ofl_rst_n rises
) (
   input  wire logic              iclk,
   input  wire logic              ireset_n,
   flash_byte_reader_if.slave     req,
   output logic [22:0]            ofl_addr,
   input  wire logic [7:0]        ifl_dq,
   output logic                   ofl_ce_n,
   output logic                   ofl_oe_n,
   output logic                   ofl_we_n,
   output logic                   ofl_rst_n,
   output logic                   ofl_wp_n
);

   // Terminal counts: the timer counts 0..N-1, the transition fires on N-1.
   localparam logic [15:0] ACC_LAST      = 16'(ACCESS_CYCLES - 1);
   localparam logic [15:0] RST_LOW_LAST  = 16'(RST_LOW_CYCLES - 1);
   localparam logic [15:0] RST_WAIT_LAST = 16'(RST_WAIT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_RST_LOW  = 3'd0,
      ST_RST_WAIT = 3'd1,
      ST_IDLE     = 3'd2,
      ST_READ_LO  = 3'd3,
      ST_READ_HI  = 3'd4
   } state_t;

   state_t      state;
   logic [15:0] timer;
   logic [7:0]  even_byte;

   // The flash is only ever read.
   assign ofl_we_n = 1'b1;
   assign ofl_wp_n = 1'b0;

   // Reset sequencing and two-byte read controller; all outputs registered.
   always_ff @(posedge iclk or negedge ireset_n) begin
      if (!ireset_n) begin
         state      <= ST_RST_LOW;
         timer      <= 16'd0;
         even_byte  <= 8'd0;
         req.oack   <= 1'b0;
         req.odata  <= 16'd0;
         req.oready <= 1'b0;
         ofl_addr   <= 23'd0;
         ofl_ce_n   <= 1'b1;
         ofl_oe_n   <= 1'b1;
         ofl_rst_n  <= 1'b0;
      end else begin
         case (state)
            ST_RST_LOW: begin
               if (timer == RST_LOW_LAST) begin
                  ofl_rst_n <= 1'b1;
                  timer     <= 16'd0;
                  state     <= ST_RST_WAIT;
               end else begin
                  timer <= timer + 16'd1;
               end
            end

            ST_RST_WAIT: begin
               if (timer == RST_WAIT_LAST) begin
                  req.oready <= 1'b1;
                  timer      <= 16'd0;
                  state      <= ST_IDLE;
               end else begin
                  timer <= timer + 16'd1;
               end
            end

            ST_IDLE: begin
               // Requests raised during the reset sequence are still pending
               // here and get served on the first IDLE cycle.
               if (req.ireq != req.oack) begin
                  ofl_addr <= req.iaddr & 23'h7F_FFFE;
                  ofl_ce_n <= 1'b0;
                  ofl_oe_n <= 1'b0;
                  timer    <= 16'd0;
                  state    <= ST_READ_LO;
               end
            end

            ST_READ_LO: begin
               // ce_n/oe_n stay low; only address bit 0 flips to the odd byte.
               if (timer == ACC_LAST) begin
                  even_byte   <= ifl_dq;
                  ofl_addr[0] <= 1'b1;
                  timer       <= 16'd0;
                  state       <= ST_READ_HI;
               end else begin
                  timer <= timer + 16'd1;
               end
            end

            ST_READ_HI: begin
               if (timer == ACC_LAST) begin
`ifdef FLASH_BYTESWAP_EN
                  req.odata <= {ifl_dq, even_byte};
`else
                  req.odata <= {even_byte, ifl_dq};
`endif
                  req.oack  <= ~req.oack;
                  ofl_ce_n  <= 1'b1;
                  ofl_oe_n  <= 1'b1;
                  timer     <= 16'd0;
                  state     <= ST_IDLE;
               end else begin
                  timer <= timer + 16'd1;
               end
            end

            default: begin
               state <= ST_RST_LOW;
               timer <= 16'd0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
